// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared owner/state encodings and latency counter width for the memory port arbiter
package mem_arb_pkg;
   typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2} owner_t;
   typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;
   localparam int LAT_CNT_W = 4;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select between fetch and data ports; ARB_ROUND_ROBIN_EN selects round-robin tie-break, else fixed D-over-I
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic   i_req,
   input  logic   d_req,
`ifdef ARB_ROUND_ROBIN_EN
   input  owner_t rr_last,
`endif
   output owner_t win
);
   // A lone request wins outright; only a tie consults the policy
   always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
      win = (i_req && d_req) ? ((rr_last == OWN_D) ? OWN_I : OWN_D) :
            d_req ? OWN_D : i_req ? OWN_I : OWN_NONE;
`else
      win = d_req ? OWN_D : i_req ? OWN_I : OWN_NONE;
`endif
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data ports, one transaction outstanding; ARB_ROUND_ROBIN_EN enables round-robin ties
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 2
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              m_en,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              busy
);
   state_t               state, state_nxt;
   owner_t               owner, owner_nxt, win;
   logic [LAT_CNT_W-1:0] lat_cnt, lat_cnt_nxt;
   logic                 wr, wr_nxt;
   logic                 grant, done;
`ifdef ARB_ROUND_ROBIN_EN
   owner_t               rr_last;
`endif

   mem_arb_pick u_pick (
      .i_req   (i_req),
      .d_req   (d_req),
`ifdef ARB_ROUND_ROBIN_EN
      .rr_last (rr_last),
`endif
      .win     (win)
   );

   // Transaction state: owner, remaining latency and whether it was a write
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         owner   <= OWN_NONE;
         lat_cnt <= '0;
         wr      <= 1'b0;
      end else begin
         state   <= state_nxt;
         owner   <= owner_nxt;
         lat_cnt <= lat_cnt_nxt;
         wr      <= wr_nxt;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   // Remember the last granted port so the next tie goes to the other one
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rr_last <= OWN_I;
      else if (grant) rr_last <= win;
   end
`endif

   // Grant only from IDLE; the rvalid cycle is still WAIT, so it never overlaps a grant
   always_comb begin
      grant       = !reset && state == ST_IDLE && win != OWN_NONE;
      done        = state == ST_WAIT && lat_cnt == '0;
      state_nxt   = grant ? ST_WAIT : done ? ST_IDLE : state;
      owner_nxt   = grant ? win : done ? OWN_NONE : owner;
      lat_cnt_nxt = grant ? LAT_CNT_W'(MEM_LAT - 1) :
                    (state == ST_WAIT && lat_cnt != '0) ? lat_cnt - LAT_CNT_W'(1) : lat_cnt;
      wr_nxt      = grant ? (win == OWN_D && d_we) : wr;
      i_gnt       = grant && win == OWN_I;
      d_gnt       = grant && win == OWN_D;
      m_en        = grant;
      m_we        = d_gnt && d_we;
      m_addr      = d_gnt ? d_addr : i_gnt ? i_addr : '0;
      m_wdata     = m_we ? d_wdata : '0;
      i_rvalid    = done && owner == OWN_I;
      d_rvalid    = done && owner == OWN_D;
      i_rdata     = i_rvalid ? m_rdata : '0;
      d_rdata     = (d_rvalid && !wr) ? m_rdata : '0;
      busy        = state == ST_WAIT;
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter (MEM_LAT=2 instance plus a MEM_LAT=1 instance)
module tb_mem_port_arbiter;
   typedef struct {bit is_d; logic [15:0] data; int due;} exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, d_req, d_we;
   logic [15:0] i_addr, d_addr, d_wdata;
   logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_en, m_we, busy;
   logic [15:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;

   logic        i1_req;
   logic [15:0] i1_addr;
   logic        i1_gnt, i1_rvalid, d1_gnt, d1_rvalid, m1_en, m1_we, busy1;
   logic [15:0] i1_rdata, d1_rdata, m1_addr, m1_wdata, m1_rdata;
   logic        d1_req = 1'b0, d1_we = 1'b0;
   logic [15:0] d1_addr = 16'h0, d1_wdata = 16'h0;

   logic [15:0] mem [256] = '{4: 16'h1283, 5: 16'h2A01, default: 16'h0};
   logic [15:0] p1, p2, q1;
   int          cyc = 0;
   int          passed = 0, total = 0;
   exp_t        sb[$];
   exp_t        e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
      .busy(busy)
   );

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut1 (
      .clk(clk), .reset(reset),
      .i_req(i1_req), .i_addr(i1_addr), .i_gnt(i1_gnt), .i_rvalid(i1_rvalid), .i_rdata(i1_rdata),
      .d_req(d1_req), .d_we(d1_we), .d_addr(d1_addr), .d_wdata(d1_wdata),
      .d_gnt(d1_gnt), .d_rvalid(d1_rvalid), .d_rdata(d1_rdata),
      .m_en(m1_en), .m_we(m1_we), .m_addr(m1_addr), .m_wdata(m1_wdata), .m_rdata(m1_rdata),
      .busy(busy1)
   );

   // Memory model: write at the issue edge, read data appears MEM_LAT cycles after issue
   always @(posedge clk) begin
      if (m_en && m_we) mem[m_addr[7:0]] <= m_wdata;
      p1 <= m_en ? mem[m_addr[7:0]] : 16'h0;
      p2 <= p1;
      q1 <= m1_en ? mem[m1_addr[7:0]] : 16'h0;
   end
   assign m_rdata  = p2;
   assign m1_rdata = q1;

   // Scoreboard: every rvalid must match the oldest expected completion
   always @(negedge clk) begin
      if (i_rvalid || d_rvalid) begin
         total++;
         if (sb.size() == 0)
            $display("FAIL sb_unexpected: i_rvalid=%0b d_rvalid=%0b at cycle %0d, expected none", i_rvalid, d_rvalid, cyc);
         else begin
            e = sb.pop_front();
            if (d_rvalid !== e.is_d || i_rvalid !== !e.is_d || (e.is_d ? d_rdata : i_rdata) !== e.data || cyc !== e.due)
               $display("FAIL sb_rvalid: got d=%0b i=%0b data=%h cyc=%0d, expected d=%0b data=%h cyc=%0d",
                        d_rvalid, i_rvalid, e.is_d ? d_rdata : i_rdata, cyc, e.is_d, e.data, e.due);
            else passed++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input bit is_d, input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] exp_data);
      int n;
      n = 0;
      if (is_d) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
      else begin i_req = 1'b1; i_addr = addr; end
      @(negedge clk);
      while (!(is_d ? d_gnt : i_gnt) && n < 20) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n == 20)
         $display("FAIL gnt_timeout: no grant for port d=%0b after 20 cycles, expected a grant", is_d);
      else if (m_en !== 1'b1 || m_we !== (is_d && we) || m_addr !== addr || (is_d ? i_gnt : d_gnt) !== 1'b0 ||
               (is_d && we && m_wdata !== wdata))
         $display("FAIL gnt_cmd: m_en=%0b m_we=%0b m_addr=%h m_wdata=%h, expected en=1 we=%0b addr=%h wdata=%h",
                  m_en, m_we, m_addr, m_wdata, is_d && we, addr, wdata);
      else begin
         passed++;
         sb.push_back('{is_d, exp_data, cyc + 2});
      end
      tick();
      if (is_d) d_req = 1'b0; else i_req = 1'b0;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      sb.delete();
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      i_req = 1'b1; d_req = 1'b1; i_addr = 16'h0004; d_addr = 16'h0010;
      @(negedge clk);
      total++;
      if ({i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, busy} !== '0)
         $display("FAIL reset_ports: gnt=%0b/%0b rvalid=%0b/%0b busy=%0b, expected all 0", i_gnt, d_gnt, i_rvalid, d_rvalid, busy);
      else passed++;
      total++;
      if ({m_en, m_we, m_addr, m_wdata} !== '0)
         $display("FAIL reset_mem: m_en=%0b m_we=%0b m_addr=%h m_wdata=%h, expected all 0", m_en, m_we, m_addr, m_wdata);
      else passed++;
      i_req = 1'b0; d_req = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_fetch;
      tick();
      issue(1'b0, 1'b0, 16'h0004, 16'h0, 16'h1283);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         total++;
         if (busy !== (k < 3)) $display("FAIL fetch_busy: busy=%0b at T+%0d, expected %0b", busy, k, k < 3);
         else passed++;
      end
   endtask

   task automatic test_write;
      tick();
      issue(1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000);
      tick();
      tick();
      issue(1'b1, 1'b0, 16'h0010, 16'h0, 16'hBEEF);
      repeat (3) tick();
   endtask

   task automatic test_priority;
      bit ei, ed;
      do_reset();
      i_req = 1'b1; i_addr = 16'h0004;
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
         ed = (k % 3 == 0) && ((k / 3) % 2 == 0);
         ei = (k % 3 == 0) && ((k / 3) % 2 == 1);
`else
         ed = (k % 3 == 0);
         ei = 1'b0;
`endif
         total++;
         if (i_gnt !== ei || d_gnt !== ed)
            $display("FAIL tie_grant: cycle %0d i_gnt=%0b d_gnt=%0b, expected i=%0b d=%0b", k, i_gnt, d_gnt, ei, ed);
         else passed++;
         if (ed) sb.push_back('{1'b1, 16'hBEEF, cyc + 2});
         if (ei) sb.push_back('{1'b0, 16'h1283, cyc + 2});
         tick();
      end
      i_req = 1'b0; d_req = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_withdraw;
      tick();
      issue(1'b1, 1'b0, 16'h0010, 16'h0, 16'hBEEF);
      i_req = 1'b1; i_addr = 16'h0005;
      @(negedge clk);
      total++;
      if (i_gnt !== 1'b0) $display("FAIL withdraw_wait: i_gnt=%0b during WAIT, expected 0", i_gnt);
      else passed++;
      tick();
      i_req = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         total++;
         if (i_gnt !== 1'b0 || m_en !== 1'b0 || (k > 0 && busy !== 1'b0))
            $display("FAIL withdraw_idle: i_gnt=%0b m_en=%0b busy=%0b, expected 0", i_gnt, m_en, busy);
         else passed++;
         tick();
      end
   endtask

   task automatic test_reset_mid;
      tick();
      issue(1'b0, 1'b0, 16'h0005, 16'h0, 16'h2A01);
      reset = 1'b1;
      sb.delete();
      i_req = 1'b1; i_addr = 16'h0004;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total++;
         if ({i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, busy, m_en, m_we, m_addr, m_wdata} !== '0)
            $display("FAIL reset_mid: i_gnt=%0b i_rvalid=%0b busy=%0b m_en=%0b m_addr=%h, expected all 0",
                     i_gnt, i_rvalid, busy, m_en, m_addr);
         else passed++;
      end
      tick();
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (i_gnt !== 1'b1 || m_addr !== 16'h0004)
         $display("FAIL reset_regrant: i_gnt=%0b m_addr=%h, expected 1 and 0004", i_gnt, m_addr);
      else begin
         passed++;
         sb.push_back('{1'b0, 16'h1283, cyc + 2});
      end
      tick();
      i_req = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_back_to_back;
      bit eg, ev;
      tick();
      i1_req = 1'b1; i1_addr = 16'h0005;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         eg = (k % 2 == 0);
         ev = (k % 2 == 1);
         total++;
         if (i1_gnt !== eg || i1_rvalid !== ev || i1_rdata !== (ev ? 16'h2A01 : 16'h0) || m1_addr !== (eg ? 16'h0005 : 16'h0))
            $display("FAIL b2b_lat1: cycle %0d gnt=%0b rvalid=%0b rdata=%h m_addr=%h, expected gnt=%0b rvalid=%0b",
                     k, i1_gnt, i1_rvalid, i1_rdata, m1_addr, eg, ev);
         else passed++;
         tick();
      end
      i1_req = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      reset = 1'b1;
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
      i1_req = 1'b0; i1_addr = 16'h0;
      tick();
      test_reset();
      test_fetch();
      test_write();
      test_priority();
      test_withdraw();
      test_reset_mid();
      test_back_to_back();
      total++;
      if (sb.size() != 0) $display("FAIL sb_pending: %0d completions outstanding, expected 0", sb.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
